// File: rtl/hazard_sched_pkg.sv
// Shared definitions for the hazard_sched pipeline sequencing controller.
//   state_e     : sequencer state encoding (RUN / BR_WAIT), visible on sb_state
//   REG_ZERO    : architectural $zero; never produces or suffers a hazard
//   sb_entry_t  : one scoreboard slot {valid, dest}
package hazard_sched_pkg;

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_BR_WAIT = 1'b1
   } state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic       valid;
      logic [4:0] dest;
   } sb_entry_t;

   // An operand can only hazard if it is actually read and is not $zero.
   function automatic logic reads_reg(input logic use_reg, input logic [4:0] r);
      return use_reg & (r != REG_ZERO);
   endfunction

endpackage

// File: rtl/hazard_sched_sb_shift.sv
// Destination-register scoreboard for the in-flight EX/MEM/WB instructions.
// Entry 0 is the EX occupant; the whole array shifts every cycle because the
// downstream stages never stall, and the oldest entry simply drops out.
// Two compare ports report whether a register is pending a write. With
// WB_BYPASS=1 the oldest slot is masked from the compare: the regfile writes
// before it reads, so the WB occupant is already visible to ID.
//   clk, rst          : clock, async active-high reset (clears all entries)
//   push_valid        : a regfile-writing instruction leaves ID this cycle
//   push_dest         : its destination register
//   rd_a, rd_b        : registers to look up
//   hit_a, hit_b      : register has a pending write in a compared slot
module hazard_sched_sb_shift
   import hazard_sched_pkg::*;
#(
   parameter int DEPTH     = 3,
   parameter int WB_BYPASS = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push_valid,
   input  logic [4:0] push_dest,
   input  logic [4:0] rd_a,
   input  logic [4:0] rd_b,
   output logic       hit_a,
   output logic       hit_b
);

   localparam int CMP_N = (WB_BYPASS != 0) ? DEPTH - 1 : DEPTH;

   sb_entry_t [DEPTH-1:0] sb_q;
   sb_entry_t [DEPTH-1:0] sb_d;

   always_comb begin
      sb_d          = sb_q;
      sb_d[0].valid = push_valid & (push_dest != REG_ZERO);
      sb_d[0].dest  = push_dest;
      for (int i = 1; i < DEPTH; i++) begin
         sb_d[i] = sb_q[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sb_q <= '0;
      end else begin
         sb_q <= sb_d;
      end
   end

   always_comb begin
      hit_a = 1'b0;
      hit_b = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((i < CMP_N) && sb_q[i].valid && (sb_q[i].dest == rd_a)) hit_a = 1'b1;
         if ((i < CMP_N) && sb_q[i].valid && (sb_q[i].dest == rd_b)) hit_b = 1'b1;
      end
   end

endmodule

// File: rtl/hazard_sched.sv
// Pipeline sequencing controller for the 5-stage MIPS core (beside ID).
// Interlock-only: stalls PC and IF/ID on read-after-write hazards, injects
// ID/EX bubbles, and squashes wrong-path fetch while a branch resolves.
//   clk, rst                 : clock, async active-high reset
//   id_rs/id_rt, id_use_*    : source operands of the instruction in ID
//   id_wreg, id_dest         : ID instruction writes id_dest
//   id_branch                : ID instruction is a branch
//   br_resolve, br_taken     : branch outcome from EX/MEM (ignored in RUN)
//   pc_we, pc_sel            : PC load enable / load branch target
//   ifid_we, ifid_flush      : IF/ID load enable / load NOP (flush wins)
//   idex_bubble              : load NOP into ID/EX
//   sb_state                 : 0 = RUN, 1 = BR_WAIT
//   br_err                   : sticky branch-resolve timeout flag
//   stall_cnt, flush_cnt     : saturating RAW-stall / BR_WAIT cycle counts
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal issue; stall on RAW, launch a branch into BR_WAIT
// BR_WAIT  | branch in flight; fetch squashed until resolve or timeout
module hazard_sched
   import hazard_sched_pkg::*;
#(
   parameter int DEPTH     = 3,
   parameter int WB_BYPASS = 1,
   parameter int BR_MAX    = 8,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_wreg,
   input  logic [4:0]       id_dest,
   input  logic             id_branch,
   input  logic             br_resolve,
   input  logic             br_taken,
   output logic             pc_we,
   output logic             pc_sel,
   output logic             ifid_we,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             sb_state,
   output logic             br_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   // Branch timer counts down from BR_MAX-1; terminal count 0 is the
   // BR_MAX-th BR_WAIT cycle.
   localparam logic [7:0] BR_TMR_INIT = 8'(BR_MAX - 1);

   state_e           state_q, state_d;
   logic [7:0]       br_tmr_q, br_tmr_d;
   logic             br_err_q, br_err_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic hit_rs, hit_rt;
   logic raw;
   logic sb_push;

   hazard_sched_sb_shift #(
      .DEPTH     (DEPTH),
      .WB_BYPASS (WB_BYPASS)
   ) u_sb (
      .clk        (clk),
      .rst        (rst),
      .push_valid (sb_push & id_wreg),
      .push_dest  (id_dest),
      .rd_a       (id_rs),
      .rd_b       (id_rt),
      .hit_a      (hit_rs),
      .hit_b      (hit_rt)
   );

   assign raw = (reads_reg(id_use_rs, id_rs) & hit_rs) |
                (reads_reg(id_use_rt, id_rt) & hit_rt);

   always_comb begin
      state_d     = state_q;
      br_tmr_d    = br_tmr_q;
      br_err_d    = br_err_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      pc_we       = 1'b0;
      pc_sel      = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b1;
      sb_push     = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (raw) begin
               if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
            end else begin
               pc_we       = 1'b1;
               ifid_we     = 1'b1;
               idex_bubble = 1'b0;
               sb_push     = 1'b1;
               if (id_branch) begin
                  // Branch goes down the pipe; whatever was fetched behind
                  // it is wrong-path until it resolves.
                  pc_we      = 1'b0;
                  ifid_flush = 1'b1;
                  state_d    = ST_BR_WAIT;
                  br_tmr_d   = BR_TMR_INIT;
               end
            end
         end
         ST_BR_WAIT: begin
            ifid_we    = 1'b1;
            ifid_flush = 1'b1;
            if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
            if (br_resolve) begin
               pc_we   = 1'b1;
               pc_sel  = br_taken;
               state_d = ST_RUN;
            end else if (br_tmr_q == '0) begin
               // Give up on the branch and fall through so the core keeps
               // moving; br_err records that it happened.
               pc_we    = 1'b1;
               br_err_d = 1'b1;
               state_d  = ST_RUN;
            end else begin
               br_tmr_d = br_tmr_q - 1'b1;
            end
         end
         default: state_d = ST_RUN;
      endcase

      if (rst) begin
         pc_we       = 1'b0;
         pc_sel      = 1'b0;
         ifid_we     = 1'b0;
         ifid_flush  = 1'b0;
         idex_bubble = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_RUN;
         br_tmr_q    <= '0;
         br_err_q    <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         br_tmr_q    <= br_tmr_d;
         br_err_q    <= br_err_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign sb_state  = (state_q == ST_BR_WAIT);
   assign br_err    = br_err_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_sched.sv
// Two hazard_sched instances share one stimulus stream: A uses the default
// parameters, B uses WB_BYPASS=0, BR_MAX=4, CNT_W=3. The reference model keeps
// the cycle number of the last issued write to each register and the cycle a
// branch issued; hazards and timeouts fall out of cycle differences.
module tb_hazard_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs, id_rt, id_dest;
   logic       id_use_rs, id_use_rt, id_wreg, id_branch, br_resolve, br_taken;

   logic        pc_we_a, pc_sel_a, ifid_we_a, ifid_flush_a, idex_bubble_a, sb_state_a, br_err_a;
   logic [15:0] stall_cnt_a, flush_cnt_a;
   logic        pc_we_b, pc_sel_b, ifid_we_b, ifid_flush_b, idex_bubble_b, sb_state_b, br_err_b;
   logic [2:0]  stall_cnt_b, flush_cnt_b;

   always #5 clk = ~clk;

   hazard_sched #(.DEPTH(3), .WB_BYPASS(1), .BR_MAX(8), .CNT_W(16)) u_dut_a (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
      .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_dest(id_dest), .id_branch(id_branch),
      .br_resolve(br_resolve), .br_taken(br_taken), .pc_we(pc_we_a), .pc_sel(pc_sel_a),
      .ifid_we(ifid_we_a), .ifid_flush(ifid_flush_a), .idex_bubble(idex_bubble_a),
      .sb_state(sb_state_a), .br_err(br_err_a), .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
   );

   hazard_sched #(.DEPTH(3), .WB_BYPASS(0), .BR_MAX(4), .CNT_W(3)) u_dut_b (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
      .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_dest(id_dest), .id_branch(id_branch),
      .br_resolve(br_resolve), .br_taken(br_taken), .pc_we(pc_we_b), .pc_sel(pc_sel_b),
      .ifid_we(ifid_we_b), .ifid_flush(ifid_flush_b), .idex_bubble(idex_bubble_b),
      .sb_state(sb_state_b), .br_err(br_err_b), .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
   );

   typedef struct {
      bit pc_we, pc_sel, ifid_we, ifid_flush, idex_bubble, sb_state, br_err;
      int stall, flush;
      int cyc;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state, index 0 = instance A, 1 = instance B.
   int m_cyc = 0;
   int m_last_wr [2][32];
   bit m_brw [2];
   int m_br_issue [2];
   bit m_err [2];
   int m_stall [2];
   int m_flush [2];
   // Hazard window in cycles since issue: EX,MEM (2) or EX,MEM,WB (3).
   int P_WIN   [2] = '{2, 3};
   int P_BRMAX [2] = '{8, 4};
   int P_SAT   [2] = '{65535, 7};

   task automatic model_reset(input int k);
      for (int r = 0; r < 32; r++) m_last_wr[k][r] = -100;
      m_brw[k]   = 1'b0;
      m_err[k]   = 1'b0;
      m_stall[k] = 0;
      m_flush[k] = 0;
   endtask

   function automatic bit hz(input int k, input bit u, input logic [4:0] r);
      return u && (r != 5'd0) && ((m_cyc - m_last_wr[k][r]) <= P_WIN[k]);
   endfunction

   function automatic int sat(input int k, input int v);
      return (v > P_SAT[k]) ? P_SAT[k] : v;
   endfunction

   task automatic model_step(input int k, output exp_t e);
      int n;
      e = '{default: 0};
      e.cyc = m_cyc;
      if (rst) begin
         model_reset(k);
         e.idex_bubble = 1'b1;
      end else begin
         e.sb_state = m_brw[k];
         e.br_err   = m_err[k];
         e.stall    = m_stall[k];
         e.flush    = m_flush[k];
         if (!m_brw[k]) begin
            if (hz(k, id_use_rs, id_rs) || hz(k, id_use_rt, id_rt)) begin
               e.idex_bubble = 1'b1;
               m_stall[k] = sat(k, m_stall[k] + 1);
            end else begin
               e.ifid_we = 1'b1;
               if (id_wreg && id_dest != 5'd0) m_last_wr[k][id_dest] = m_cyc;
               if (id_branch) begin
                  e.ifid_flush  = 1'b1;
                  m_brw[k]      = 1'b1;
                  m_br_issue[k] = m_cyc;
               end else begin
                  e.pc_we = 1'b1;
               end
            end
         end else begin
            n = m_cyc - m_br_issue[k];
            e.idex_bubble = 1'b1;
            e.ifid_flush  = 1'b1;
            m_flush[k] = sat(k, m_flush[k] + 1);
            if (br_resolve) begin
               e.pc_we  = 1'b1;
               e.pc_sel = br_taken;
               m_brw[k] = 1'b0;
            end else if (n == P_BRMAX[k]) begin
               e.pc_we  = 1'b1;
               m_err[k] = 1'b1;
               m_brw[k] = 1'b0;
            end
         end
      end
   endtask

   task automatic drv(input bit r, input int rs, input int rt, input bit urs, input bit urt,
                      input bit wreg, input int dest, input bit br, input bit res, input bit tk);
      exp_t ea, eb;
      @(posedge clk);
      #1;
      rst        = r;
      id_rs      = 5'(rs);
      id_rt      = 5'(rt);
      id_use_rs  = urs;
      id_use_rt  = urt;
      id_wreg    = wreg;
      id_dest    = 5'(dest);
      id_branch  = br;
      br_resolve = res;
      br_taken   = tk;
      model_step(0, ea);
      model_step(1, eb);
      q_a.push_back(ea);
      q_b.push_back(eb);
      m_cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic chk(input string name, input int cyc, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q_a.size() > 0) begin
         e = q_a.pop_front();
         chk("a.pc_we", e.cyc, int'(pc_we_a), int'(e.pc_we));
         chk("a.pc_sel", e.cyc, int'(pc_sel_a), int'(e.pc_sel));
         chk("a.ifid_flush", e.cyc, int'(ifid_flush_a), int'(e.ifid_flush));
         if (!e.ifid_flush) chk("a.ifid_we", e.cyc, int'(ifid_we_a), int'(e.ifid_we));
         chk("a.idex_bubble", e.cyc, int'(idex_bubble_a), int'(e.idex_bubble));
         chk("a.sb_state", e.cyc, int'(sb_state_a), int'(e.sb_state));
         chk("a.br_err", e.cyc, int'(br_err_a), int'(e.br_err));
         chk("a.stall_cnt", e.cyc, int'(stall_cnt_a), e.stall);
         chk("a.flush_cnt", e.cyc, int'(flush_cnt_a), e.flush);
      end
      if (q_b.size() > 0) begin
         e = q_b.pop_front();
         chk("b.pc_we", e.cyc, int'(pc_we_b), int'(e.pc_we));
         chk("b.pc_sel", e.cyc, int'(pc_sel_b), int'(e.pc_sel));
         chk("b.ifid_flush", e.cyc, int'(ifid_flush_b), int'(e.ifid_flush));
         if (!e.ifid_flush) chk("b.ifid_we", e.cyc, int'(ifid_we_b), int'(e.ifid_we));
         chk("b.idex_bubble", e.cyc, int'(idex_bubble_b), int'(e.idex_bubble));
         chk("b.sb_state", e.cyc, int'(sb_state_b), int'(e.sb_state));
         chk("b.br_err", e.cyc, int'(br_err_b), int'(e.br_err));
         chk("b.stall_cnt", e.cyc, int'(stall_cnt_b), e.stall);
         chk("b.flush_cnt", e.cyc, int'(flush_cnt_b), e.flush);
      end
   end

   initial begin
      rst = 1'b1;
      id_rs = '0; id_rt = '0; id_dest = '0;
      id_use_rs = 0; id_use_rt = 0; id_wreg = 0; id_branch = 0; br_resolve = 0; br_taken = 0;
      model_reset(0);
      model_reset(1);

      drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(2);

      // Back-to-back RAW on $3: A stalls 2 cycles, B stalls 3.
      drv(0, 0, 0, 0, 0, 1, 3, 0, 0, 0);
      for (int i = 0; i < 4; i++) drv(0, 3, 0, 1, 0, 1, 6, 0, 0, 0);
      idle(4);

      // $zero and unused operands never stall.
      drv(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      drv(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
      drv(0, 0, 0, 0, 0, 1, 5, 0, 0, 0);
      drv(0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
      idle(3);

      // Taken branch resolved two cycles after issue.
      drv(0, 1, 2, 1, 1, 0, 0, 1, 0, 0);
      idle(1);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      idle(2);

      // Branch behind a load-use hazard on $4.
      drv(0, 0, 0, 0, 0, 1, 4, 0, 0, 0);
      for (int i = 0; i < 4; i++) drv(0, 4, 0, 1, 0, 0, 0, 1, 0, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      idle(3);

      // Resolve coinciding with B's timeout cycle: br_err stays clear.
      drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      idle(3);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      idle(2);

      // Never resolve: both instances time out, br_err sticks.
      drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      idle(12);

      // Reset in the middle of BR_WAIT with every scoreboard slot valid.
      drv(0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      drv(0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
      drv(0, 0, 0, 0, 0, 1, 3, 1, 0, 0);
      idle(1);
      drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drv(1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
      drv(0, 3, 2, 1, 1, 0, 0, 0, 0, 0);
      idle(2);

      // Random traffic; small register range keeps hazards frequent.
      for (int i = 0; i < 3000; i++) begin
         drv(($urandom_range(0, 199) == 0),
             $urandom_range(0, 7), $urandom_range(0, 7),
             ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
             ($urandom_range(0, 9) < 6), $urandom_range(0, 7),
             ($urandom_range(0, 99) < 15), ($urandom_range(0, 9) < 3),
             $urandom_range(0, 1) == 1);
      end
      idle(2);

      repeat (4) @(negedge clk);
      #1;
      chk("scoreboard_drained_a", m_cyc, q_a.size(), 0);
      chk("scoreboard_drained_b", m_cyc, q_b.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_sched.md
Name: hazard_sched

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core. Sits beside the decode stage.
- Keeps a destination-register scoreboard for the in-flight EX/MEM/WB instructions.
- Stalls PC and IF/ID on read-after-write hazards and injects bubbles into ID/EX.
- Squashes wrong-path fetch while a branch resolves downstream. No forwarding; interlock only.

Parameters:
DEPTH, 3, scoreboard entries (EX, MEM, WB occupants), index 0 = EX
WB_BYPASS, 1, 1: regfile write-before-read, so the oldest entry (WB) is excluded from the hazard compare
BR_MAX, 8, max BR_WAIT cycles before timeout; range 1..255
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock, posedge
rst  in  1  asynchronous reset, active-high
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_use_rs  in  1  instruction in ID reads rs
id_use_rt  in  1  instruction in ID reads rt
id_wreg  in  1  instruction in ID writes the regfile (cu_wreg)
id_dest  in  5  destination register (rt or rd, already muxed by cu_regrt)
id_branch  in  1  instruction in ID is a branch (cu_branch)
br_resolve  in  1  branch outcome valid this cycle (from EX/MEM)
br_taken  in  1  branch taken; meaningful only with br_resolve
pc_we  out  1  PC register load enable
pc_sel  out  1  1: PC loads branch target
ifid_we  out  1  IF/ID register load enable
ifid_flush  out  1  load NOP into IF/ID (overrides ifid_we)
idex_bubble  out  1  load NOP/control-zero into ID/EX
sb_state  out  1  0 = RUN, 1 = BR_WAIT
br_err  out  1  sticky, set on branch-resolve timeout
stall_cnt  out  CNT_W  saturating count of RAW-stall cycles
flush_cnt  out  CNT_W  saturating count of BR_WAIT cycles

Behaviour:
- Reset (async, rst=1): state RUN, all scoreboard entries invalid, br_cnt=0, counters=0, br_err=0.
- While rst=1, outputs are forced to pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=1, pc_sel=0.
- Reset mid-branch abandons BR_WAIT and clears the scoreboard.
- Scoreboard: DEPTH x {valid, dest[4:0]}, shifting every cycle (downstream stages never stall).
  - Entry0 <= {issue & id_wreg & (id_dest!=0), id_dest}. Entry[i] <= entry[i-1]. The oldest entry drops out.
- Hazard, combinational:
  - raw = (id_use_rs & id_rs!=0 & match(id_rs)) | (id_use_rt & id_rt!=0 & match(id_rt)).
  - match compares valid entries 0..DEPTH-2 if WB_BYPASS=1, otherwise 0..DEPTH-1.
  - $zero never hazards.
- issue = (state==RUN) & ~raw.
- RUN, no raw, no branch: pc_we=1, ifid_we=1, ifid_flush=0, idex_bubble=0.
- RUN, raw: pc_we=0, ifid_we=0, idex_bubble=1; stall_cnt++; stay RUN. Branch with raw stalls first and issues once raw clears.
- RUN, issue & id_branch:
  - Branch passes to ID/EX (idex_bubble=0); pc_we=0, ifid_flush=1.
  - Next state BR_WAIT, br_cnt=0.
- BR_WAIT:
  - pc_we=0, ifid_flush=1, idex_bubble=1, scoreboard entry0 invalid; flush_cnt++, br_cnt++.
  - br_resolve=1: pc_we=1, pc_sel=br_taken, ifid_flush=1; next state RUN.
  - br_cnt==BR_MAX-1 without resolve: br_err<=1, pc_we=1, pc_sel=0; next state RUN.
  - Resolve and timeout in the same cycle: resolve wins, br_err unchanged.
- br_resolve in RUN is ignored.
- Counters saturate at all-ones; no wrap.
- All state updates on posedge clk; outputs are combinational from state, scoreboard and ID inputs.

Decomposition:
- Shared package/header (pipe_ctrl.vh): state encodings ST_RUN/ST_BR_WAIT, REG_ZERO=5'd0, NOP word 32'h0000_0000.
- One sub-module: sb_shift (DEPTH-entry valid/dest shift register with two 5-bit compare ports and a WB_BYPASS mask).
- FSM and counters stay in hazard_sched.

Test Plan:
- Reset: assert rst mid BR_WAIT with all entries valid -> pc_we=0, idex_bubble=1 during reset; after release sb_state=0, br_err=0, stall_cnt=0, pc_we=1.
- Back-to-back RAW: issue add $3 (id_wreg=1, id_dest=3), then sub reading rs=3 -> 2 stall cycles (EX, MEM) with WB_BYPASS=1, stall_cnt=2; with WB_BYPASS=0 -> 3 cycles.
- $zero and unused operand: dest=0 followed by rs=0 reader; and dest=5 followed by id_use_rt=0, rt=5 -> no stall, stall_cnt stays 0.
- Taken branch: issue beq, br_resolve=1, br_taken=1 two cycles later -> ifid_flush high 3 cycles, pc_sel=1 on resolve cycle, flush_cnt=2, back to RUN.
- Branch behind hazard: lw $4 then beq reading $4 -> stalls first, branch issues when raw clears, then enters BR_WAIT; no early PC load.
- Timeout: BR_MAX=4, branch issued, never resolve -> pc_we=1 after 4 BR_WAIT cycles, br_err=1 sticky; resolve coinciding with the 4th cycle -> br_err stays 0.
